// File: rtl/display_scan_controller.sv
// Eight-digit multiplexed seven-segment scan controller with a frame-synchronised
// display shadow: loaded values only reach the segments at a frame boundary.
module display_scan_controller #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  enable_mask,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  anodes,
  output logic [6:0]  segments,
  output logic        dp,
  output logic        load_pending,
  output logic        frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [2:0]    index_q, index_d;
  logic [31:0]   staging_q, staging_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [7:0]    anodes_q, anodes_d;
  logic [6:0]    segments_q, segments_d;
  logic          dp_q, dp_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  always_comb begin
    tick        = (prescaler_q == PRE_MAX);
    boundary    = tick && (index_q == 3'd7);
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    index_d     = tick ? index_q + 3'd1 : index_q;

    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // A load landing exactly on the boundary bypasses staging so it is shown next frame.
    if (load && boundary) begin
      staging_d = value;
      shadow_d  = value;
      pending_d = 1'b0;
    end else if (load) begin
      staging_d = value;
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    nibble = shadow_q[{index_q, 2'b00} +: 4];
    case (nibble)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase

    anodes_d     = '1;
    segments_d   = '1;
    dp_d         = 1'b1;
    frame_done_d = boundary;
    if (enable_mask[index_q]) begin
      anodes_d   = ~(8'b1 << index_q);
      segments_d = glyph;
      dp_d       = ~dp_mask[index_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler_q  <= '0;
      index_q      <= '0;
      staging_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      anodes_q     <= '1;
      segments_q   <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      index_q      <= index_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      anodes_q     <= anodes_d;
      segments_q   <= segments_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anodes       = anodes_q;
  assign segments     = segments_q;
  assign dp           = dp_q;
  assign load_pending = pending_q;
  assign frame_done   = frame_done_q;

endmodule
